// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage memory requests into single bus accesses
// with lane steering, load extension, alignment checking and a bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_valid,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_busy,
  output logic        O_done,
  output logic [31:0] O_rdata,
  output logic        O_fault,
  output logic        O_misaligned,
  output logic        O_bus_stb,
  output logic        O_bus_we,
  output logic [31:0] O_bus_adr,
  output logic [3:0]  O_bus_sel,
  output logic [31:0] O_bus_dat,
  input  logic [31:0] I_bus_dat,
  input  logic        I_bus_ack,
  input  logic        I_bus_err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;

  logic        req_half;
  logic        req_word;
  logic        req_legal;
  logic        req_misaligned;
  logic        req_fault;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Decode of the incoming request: legality, alignment and store lane steering.
  always_comb begin
    req_half       = (I_funct3 == 3'b001) || (!I_we && (I_funct3 == 3'b101));
    req_word       = (I_funct3 == 3'b010);
    req_legal      = I_we ? (I_funct3 <= 3'b010)
                          : !(I_funct3 inside {3'b011, 3'b110, 3'b111});
    req_misaligned = req_legal &&
                     ((req_half && I_addr[0]) || (req_word && (I_addr[1:0] != 2'b00)));
    req_fault      = !req_legal || req_misaligned;
    req_sel        = 4'b1111;
    req_dat        = I_wdata;
    if (I_we) begin
      case (I_funct3[1:0])
        2'b00: begin
          req_sel = 4'b0001 << I_addr[1:0];
          req_dat = {4{I_wdata[7:0]}};
        end
        2'b01: begin
          req_sel = I_addr[1] ? 4'b1100 : 4'b0011;
          req_dat = {2{I_wdata[15:0]}};
        end
        default: begin
          req_sel = 4'b1111;
          req_dat = I_wdata;
        end
      endcase
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane_byte = 8'(I_bus_dat >> {addr_lo_q, 3'b000});
    lane_half = addr_lo_q[1] ? I_bus_dat[31:16] : I_bus_dat[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'd0, lane_byte};
      3'b101:  load_ext = {16'd0, lane_half};
      default: load_ext = I_bus_dat;
    endcase
  end

  // Gated by reset so the stall request is low while the block is held in reset.
  assign O_busy = I_rst_n && ((state == REQ) || ((state == IDLE) && I_valid));

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      O_done       <= 1'b0;
      O_rdata      <= 32'd0;
      O_fault      <= 1'b0;
      O_misaligned <= 1'b0;
      O_bus_stb    <= 1'b0;
      O_bus_we     <= 1'b0;
      O_bus_adr    <= 32'd0;
      O_bus_sel    <= 4'd0;
      O_bus_dat    <= 32'd0;
    end else begin
      O_done       <= 1'b0;
      O_fault      <= 1'b0;
      O_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (I_valid) begin
            we_q      <= I_we;
            funct3_q  <= I_funct3;
            addr_lo_q <= I_addr[1:0];
            if (req_fault) begin
              state        <= DONE;
              O_done       <= 1'b1;
              O_fault      <= 1'b1;
              O_misaligned <= req_misaligned;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              O_bus_stb <= 1'b1;
              O_bus_we  <= I_we;
              O_bus_adr <= {I_addr[31:2], 2'b00};
              O_bus_sel <= req_sel;
              O_bus_dat <= req_dat;
            end
          end
        end
        REQ: begin
          // Error beats ack; ack beats a timeout landing in the same cycle.
          if (I_bus_err || I_bus_ack || (cnt == CNT_LAST)) begin
            state     <= DONE;
            O_done    <= 1'b1;
            O_fault   <= I_bus_err || !I_bus_ack;
            O_bus_stb <= 1'b0;
            O_bus_we  <= 1'b0;
            if (I_bus_ack && !I_bus_err && !we_q) begin
              O_rdata <= load_ext;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses checked
// against an arithmetic model of lane selection, extension and fault rules.
module tb_load_store_unit;

  localparam int TO = 4;
  localparam int NEVER = 99;

  logic        I_clk;
  logic        I_rst_n;
  logic        I_valid;
  logic        I_we;
  logic [2:0]  I_funct3;
  logic [31:0] I_addr;
  logic [31:0] I_wdata;
  logic        O_busy;
  logic        O_done;
  logic [31:0] O_rdata;
  logic        O_fault;
  logic        O_misaligned;
  logic        O_bus_stb;
  logic        O_bus_we;
  logic [31:0] O_bus_adr;
  logic [3:0]  O_bus_sel;
  logic [31:0] O_bus_dat;
  logic [31:0] I_bus_dat;
  logic        I_bus_ack;
  logic        I_bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_valid(I_valid), .I_we(I_we),
    .I_funct3(I_funct3), .I_addr(I_addr), .I_wdata(I_wdata),
    .O_busy(O_busy), .O_done(O_done), .O_rdata(O_rdata), .O_fault(O_fault),
    .O_misaligned(O_misaligned), .O_bus_stb(O_bus_stb), .O_bus_we(O_bus_we),
    .O_bus_adr(O_bus_adr), .O_bus_sel(O_bus_sel), .O_bus_dat(O_bus_dat),
    .I_bus_dat(I_bus_dat), .I_bus_ack(I_bus_ack), .I_bus_err(I_bus_err)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected load result from the returned word, computed arithmetically.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = a[1] ? (d >> 16) : (d & 32'hFFFF);
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // One complete access; ack_at = REQ cycle index at which the bus responds.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] bdat,
                         input int ack_at, input logic err, input logic ack_too);
    int size;
    int nreq;
    logic legal, mis, efault;
    logic [3:0] esel;
    logic [31:0] edat;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    mis   = legal && ((int'(addr[1:0]) % size) != 0);
    esel  = we ? 4'(((1 << size) - 1) << addr[1:0]) : 4'hF;
    edat  = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
            (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;

    @(negedge I_clk);
    I_valid = 1'b1; I_we = we; I_funct3 = f3; I_addr = addr; I_wdata = wdata;
    #1 chk("busy_on_request", O_busy, 1);
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    if (!legal || mis) begin
      chk("fault_no_stb", O_bus_stb, 0);
      chk("fault_done", O_done, 1);
      chk("fault_flag", O_fault, 1);
      chk("fault_misaligned", O_misaligned, mis);
    end else begin
      nreq = (ack_at < TO) ? ack_at + 1 : TO;
      for (int c = 0; c < nreq; c++) begin
        chk("req_stb", O_bus_stb, 1);
        chk("req_we", O_bus_we, we);
        chk("req_adr", O_bus_adr, addr & 32'hFFFF_FFFC);
        chk("req_sel", O_bus_sel, esel);
        if (we) chk("req_dat", O_bus_dat, edat);
        chk("req_busy", O_busy, 1);
        chk("req_no_done", O_done, 0);
        I_valid = 1'($urandom); I_we = 1'($urandom); I_funct3 = 3'($urandom);
        I_addr = $urandom; I_wdata = $urandom;
        I_bus_dat = $urandom;
        if (c == ack_at) begin
          I_bus_ack = !err || ack_too;
          I_bus_err = err;
          I_bus_dat = bdat;
        end
        @(posedge I_clk); #1;
        I_bus_ack = 1'b0; I_bus_err = 1'b0;
      end
      efault = (ack_at >= TO) || err;
      if (!efault && !we) model_rdata = load_model(f3, addr[1:0], bdat);
      chk("done_pulse", O_done, 1);
      chk("done_stb_low", O_bus_stb, 0);
      chk("done_fault", O_fault, efault);
      chk("done_misaligned", O_misaligned, 0);
    end
    chk("done_busy", O_busy, 0);
    chk("done_rdata", O_rdata, model_rdata);
    I_valid = 1'($urandom);
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    chk("after_done", O_done, 0);
    chk("after_fault", O_fault, 0);
    chk("after_misaligned", O_misaligned, 0);
    chk("after_rdata", O_rdata, model_rdata);
  endtask

  initial begin
    I_rst_n = 1'b0; I_valid = 1'b1; I_we = 1'b0; I_funct3 = 3'd0;
    I_addr = 32'd0; I_wdata = 32'd0; I_bus_dat = 32'd0;
    I_bus_ack = 1'b0; I_bus_err = 1'b0;
    #2;
    chk("rst_busy", O_busy, 0);
    chk("rst_done", O_done, 0);
    chk("rst_stb", O_bus_stb, 0);
    chk("rst_rdata", O_rdata, 0);
    chk("rst_adr", O_bus_adr, 0);
    chk("rst_sel", O_bus_sel, 0);
    chk("rst_fault", O_fault, 0);
    @(negedge I_clk);
    I_valid = 1'b0;
    I_rst_n = 1'b1;
    #1 chk("idle_busy", O_busy, 0);

    // LB with sign, LHU/LH upper half, SH lane steering, misaligned LW.
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 0, 1'b0, 1'b0);
    chk("lb_result", O_rdata, 32'hFFFFFF80);
    run_txn(1'b0, 3'b101, 32'h202, 32'h0, 32'h9ABC1234, 0, 1'b0, 1'b0);
    chk("lhu_result", O_rdata, 32'h00009ABC);
    run_txn(1'b0, 3'b001, 32'h202, 32'h0, 32'h9ABC1234, 1, 1'b0, 1'b0);
    chk("lh_result", O_rdata, 32'hFFFF9ABC);
    run_txn(1'b1, 3'b001, 32'h06, 32'h1234ABCD, 32'h0, 0, 1'b0, 1'b0);
    chk("sh_keeps_rdata", O_rdata, 32'hFFFF9ABC);
    run_txn(1'b0, 3'b010, 32'h01, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // Timeout, then error with simultaneous ack on a store and on a load.
    run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, NEVER, 1'b0, 1'b0);
    run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1, 1'b1, 1'b1);
    run_txn(1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 0, 1'b1, 1'b1);
    chk("err_keeps_rdata", O_rdata, 32'hFFFF9ABC);
    run_txn(1'b0, 3'b110, 32'h21, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 0, 1'b0, 1'b0);

    // Reset in the middle of a bus access.
    @(negedge I_clk);
    I_valid = 1'b1; I_we = 1'b0; I_funct3 = 3'b010; I_addr = 32'h40;
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    chk("pre_rst_stb", O_bus_stb, 1);
    @(posedge I_clk); #1;
    I_rst_n = 1'b0;
    #1;
    model_rdata = 32'd0;
    chk("midrst_stb", O_bus_stb, 0);
    chk("midrst_busy", O_busy, 0);
    chk("midrst_adr", O_bus_adr, 0);
    chk("midrst_rdata", O_rdata, 0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge I_clk); #1;
      chk("postrst_no_done", O_done, 0);
      chk("postrst_no_stb", O_bus_stb, 0);
    end
    run_txn(1'b0, 3'b100, 32'h41, 32'h0, 32'h0000C300, 0, 1'b0, 1'b0);
    chk("postrst_lbu", O_rdata, 32'h000000C3);

    // Randomized accesses.
    for (int n = 0; n < 120; n++) begin
      logic [2:0] f3;
      logic [31:0] addr;
      logic we;
      int ack_at;
      logic err;
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 9) < 7) f3 = we ? 3'($urandom_range(0, 2)) : 3'(f3 & 3'b101);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'($urandom_range(0, 3) & {2{f3 == 3'd0}});
      ack_at = $urandom_range(0, TO + 1);
      err = ($urandom_range(0, 7) == 0);
      run_txn(we, f3, addr, $urandom, $urandom, ack_at, err, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge I_clk); #1;
        chk("idle_no_done", O_done, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum REQ-state cycles before the bus access is abandoned.
REQ-002 I_clk  input  1  clock; all state updates on the rising edge.
REQ-003 I_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 I_valid  input  1  memory request from execute stage.
REQ-005 I_we  input  1  1 = store, 0 = load.
REQ-006 I_funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 I_addr  input  32  byte address.
REQ-008 I_wdata  input  32  store data, right-aligned.
REQ-009 O_busy  output  1  stall request to pipeline.
REQ-010 O_done  output  1  one-cycle completion pulse.
REQ-011 O_rdata  output  32  extended load result; feeds the writeback-select multiplexer memory input.
REQ-012 O_fault  output  1  valid with O_done; access failed.
REQ-013 O_misaligned  output  1  valid with O_done; fault cause is alignment.
REQ-014 O_bus_stb  output  1  bus request strobe.
REQ-015 O_bus_we  output  1  bus write enable.
REQ-016 O_bus_adr  output  32  word address; bits [1:0] always 00.
REQ-017 O_bus_sel  output  4  byte-lane enables.
REQ-018 O_bus_dat  output  32  lane-aligned write data.
REQ-019 I_bus_dat  input  32  read data, valid with I_bus_ack.
REQ-020 I_bus_ack  input  1  bus access complete.
REQ-021 I_bus_err  input  1  bus access error; terminates the access like I_bus_ack.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, DONE.
REQ-023 In IDLE with I_valid=1, the block SHALL latch I_we, I_funct3, I_addr and I_wdata.
REQ-024 A latched request SHALL be faulty when: halfword with addr[0]=1, word with addr[1:0]!=00, load funct3 in {011,110,111}, or store funct3 >010.
REQ-025 On a faulty request, IDLE SHALL go to DONE with O_fault=1, with O_misaligned=1 only for alignment cause, and no bus strobe.
REQ-026 On a valid request, IDLE SHALL go to REQ, with O_bus_stb=1 from the first REQ cycle.
REQ-027 Bus outputs SHALL stay constant while in REQ.
REQ-028 Store lanes SHALL be: SB sel=0001<<addr[1:0], data={4{byte}}; SH sel=addr[1]?1100:0011, data={2{half}}; SW sel=1111, data=wdata.
REQ-029 Loads SHALL use O_bus_sel=1111 and O_bus_we=0.
REQ-030 On I_bus_ack in REQ, the FSM SHALL go to DONE.
REQ-031 For loads, O_rdata SHALL be registered on that edge from byte lane addr[1:0] (LB/LBU) or half lane addr[1] (LH/LHU), sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-032 I_bus_err in REQ SHALL go to DONE with O_fault=1; it SHALL take priority over a simultaneous I_bus_ack, and O_rdata SHALL NOT be updated.
REQ-033 A 16-bit counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-034 When the counter reaches TIMEOUT_CYCLES with no ack or error, the FSM SHALL go to DONE with O_fault=1.
REQ-035 DONE SHALL last one cycle with O_done=1 and O_bus_stb=0, then return to IDLE.
REQ-036 O_fault and O_misaligned SHALL be 0 whenever O_done=0.
REQ-037 O_busy SHALL be (state==REQ) or (state==IDLE and I_valid), combinationally, and 0 in DONE.
REQ-038 I_valid SHALL be ignored outside IDLE.
REQ-039 O_rdata SHALL hold its value across stores, faults and idle cycles.
REQ-040 Minimum load latency SHALL be: request cycle, one REQ cycle with same-cycle ack, then DONE, i.e. O_done two cycles after request.

Reset
REQ-041 While I_rst_n=0, all outputs SHALL be 0, state SHALL be IDLE and the counter SHALL be 0, immediately and without a clock edge.
REQ-042 Reset during REQ SHALL drop O_bus_stb at once and discard the access with no O_done.

Verification
REQ-043 LB at addr 0x103, I_bus_dat=0x80AABBCC, ack in first REQ cycle -> O_bus_adr=0x100, sel=1111; O_done two cycles after request; O_rdata=0xFFFFFF80.
REQ-044 LHU at addr 0x202, I_bus_dat=0x9ABC1234 -> O_rdata=0x00009ABC; LH at same address -> O_rdata=0xFFFF9ABC.
REQ-045 SH at addr 0x06, wdata=0x1234ABCD -> O_bus_sel=1100, O_bus_dat=0xABCDABCD, O_bus_we=1; O_rdata unchanged.
REQ-046 LW at addr 0x01 -> no O_bus_stb; next cycle O_done=1, O_fault=1, O_misaligned=1.
REQ-047 SW with no ack and TIMEOUT_CYCLES=4 -> stb high 4 cycles, then O_done=1 and O_fault=1; a repeat with simultaneous ack and err -> fault, O_rdata unchanged.
REQ-048 I_rst_n low in mid-REQ -> O_bus_stb=0 asynchronously; after release, no O_done and state is IDLE.
